// File: rtl/alu_pkg.sv
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared encodings for the ID/EX ALU operand-select stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

   localparam int ALU_DATA_W = 32;

   localparam logic [1:0] SRC_A_RS  = 2'b00;
   localparam logic [1:0] SRC_A_RT  = 2'b01;
   localparam logic [1:0] SRC_A_IMM = 2'b10;

   localparam logic [2:0] SRC_B_RT    = 3'b000;
   localparam logic [2:0] SRC_B_RS    = 3'b001;
   localparam logic [2:0] SRC_B_IMM   = 3'b010;
   localparam logic [2:0] SRC_B_SHAMT = 3'b011;
   localparam logic [2:0] SRC_B_CONST = 3'b100;

   typedef enum logic [1:0] {
      FWD_NONE  = 2'b00,
      FWD_MEMWB = 2'b01,
      FWD_EXMEM = 2'b10
   } fwd_e;

endpackage

`default_nettype wire

// File: rtl/fwd_select.sv
// ============================================================================
// Module   : fwd_select
// Purpose  : Combinational RAW bypass for one source operand (EX/MEM first).
// Revision : 1.0
// ============================================================================
`default_nettype none

module fwd_select
   import alu_pkg::*;
#(
   parameter int DATA_W = ALU_DATA_W,
   parameter int REG_AW = 5
) (
   input  logic [REG_AW-1:0] addr,
   input  logic [DATA_W-1:0] rf_data,
   input  logic              exmem_wr,
   input  logic [REG_AW-1:0] exmem_dst,
   input  logic [DATA_W-1:0] exmem_data,
   input  logic              memwb_wr,
   input  logic [REG_AW-1:0] memwb_dst,
   input  logic [DATA_W-1:0] memwb_data,
   output logic [DATA_W-1:0] data,
   output logic [1:0]        code
);

   // Register 0 is hardwired, so a write targeting it must never be bypassed.
   always_comb begin
      data = rf_data;
      code = FWD_NONE;
      if (addr != '0) begin
         if (exmem_wr && (exmem_dst == addr)) begin
            data = exmem_data;
            code = FWD_EXMEM;
         end else if (memwb_wr && (memwb_dst == addr)) begin
            data = memwb_data;
            code = FWD_MEMWB;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/alu_operand_stage.sv
// ============================================================================
// Module   : alu_operand_stage
// Purpose  : ID/EX operand forwarding, selection and pipeline register.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_operand_stage
   import alu_pkg::*;
#(
   parameter int          DATA_W  = ALU_DATA_W,
   parameter int          REG_AW  = 5,
   parameter int unsigned CONST_B = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic              stall,
   input  logic              flush,
   input  logic [REG_AW-1:0] rs_addr,
   input  logic [REG_AW-1:0] rt_addr,
   input  logic [DATA_W-1:0] rs_data,
   input  logic [DATA_W-1:0] rt_data,
   input  logic [DATA_W-1:0] ext_imm,
   input  logic [REG_AW-1:0] shamt,
   input  logic [1:0]        alu_src_a,
   input  logic [2:0]        alu_src_b,
   input  logic              exmem_wr,
   input  logic [REG_AW-1:0] exmem_dst,
   input  logic [DATA_W-1:0] exmem_data,
   input  logic              memwb_wr,
   input  logic [REG_AW-1:0] memwb_dst,
   input  logic [DATA_W-1:0] memwb_data,
   output logic [DATA_W-1:0] in1,
   output logic [DATA_W-1:0] in2,
   output logic              out_valid,
   output logic              sel_err,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b
);

   logic [DATA_W-1:0] w_rs_fwd;
   logic [DATA_W-1:0] w_rt_fwd;
   logic [1:0]        w_rs_code;
   logic [1:0]        w_rt_code;
   logic [DATA_W-1:0] w_in1;
   logic [DATA_W-1:0] w_in2;
   logic              w_err_a;
   logic              w_err_b;

   logic [DATA_W-1:0] r_in1;
   logic [DATA_W-1:0] r_in2;
   logic              r_out_valid;
   logic              r_sel_err;
   logic [1:0]        r_fwd_a;
   logic [1:0]        r_fwd_b;

   fwd_select #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW)
   ) u_fwd_rs (
      .addr       (rs_addr),
      .rf_data    (rs_data),
      .exmem_wr   (exmem_wr),
      .exmem_dst  (exmem_dst),
      .exmem_data (exmem_data),
      .memwb_wr   (memwb_wr),
      .memwb_dst  (memwb_dst),
      .memwb_data (memwb_data),
      .data       (w_rs_fwd),
      .code       (w_rs_code)
   );

   fwd_select #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW)
   ) u_fwd_rt (
      .addr       (rt_addr),
      .rf_data    (rt_data),
      .exmem_wr   (exmem_wr),
      .exmem_dst  (exmem_dst),
      .exmem_data (exmem_data),
      .memwb_wr   (memwb_wr),
      .memwb_dst  (memwb_dst),
      .memwb_data (memwb_data),
      .data       (w_rt_fwd),
      .code       (w_rt_code)
   );

   // Illegal codes give a defined zero operand rather than a stale value.
   always_comb begin
      w_in1   = '0;
      w_err_a = 1'b0;
      case (alu_src_a)
         SRC_A_RS:  w_in1 = w_rs_fwd;
         SRC_A_RT:  w_in1 = w_rt_fwd;
         SRC_A_IMM: w_in1 = ext_imm;
         default:   w_err_a = 1'b1;
      endcase
   end

   always_comb begin
      w_in2   = '0;
      w_err_b = 1'b0;
      case (alu_src_b)
         SRC_B_RT:    w_in2 = w_rt_fwd;
         SRC_B_RS:    w_in2 = w_rs_fwd;
         SRC_B_IMM:   w_in2 = ext_imm;
         SRC_B_SHAMT: w_in2 = {{(DATA_W-REG_AW){1'b0}}, shamt};
         SRC_B_CONST: w_in2 = DATA_W'(CONST_B);
         default:     w_err_b = 1'b1;
      endcase
   end

   // Priority: reset, then flush (beats stall), then stall hold, then capture.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_in1       <= '0;
         r_in2       <= '0;
         r_out_valid <= 1'b0;
         r_sel_err   <= 1'b0;
         r_fwd_a     <= FWD_NONE;
         r_fwd_b     <= FWD_NONE;
      end else if (flush) begin
         r_in1       <= '0;
         r_in2       <= '0;
         r_out_valid <= 1'b0;
         r_sel_err   <= 1'b0;
         r_fwd_a     <= FWD_NONE;
         r_fwd_b     <= FWD_NONE;
      end else if (!stall) begin
         r_in1       <= w_in1;
         r_in2       <= w_in2;
         r_out_valid <= in_valid;
         r_sel_err   <= in_valid & (w_err_a | w_err_b);
         r_fwd_a     <= w_rs_code;
         r_fwd_b     <= w_rt_code;
      end
   end

   assign in1       = r_in1;
   assign in2       = r_in2;
   assign out_valid = r_out_valid;
   assign sel_err   = r_sel_err;
   assign fwd_a     = r_fwd_a;
   assign fwd_b     = r_fwd_b;

endmodule

`default_nettype wire

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Registered operand-select stage at the ID/EX boundary of the pipelined CPU.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB before operand selection.
- Selects ALU operands A and B from rs, rt, extended immediate, shamt or a constant.
- Presents both operands to the ALU one cycle later, with valid, stall and flush handling.
- Out-of-range select codes produce defined zero operands and an error flag instead of holding stale values.

Parameters:
- DATA_W, 32, datapath width.
- REG_AW, 5, register address width; also the shamt width.
- CONST_B, 16, constant driven when B select = 3'b100 (LUI shift amount).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous active-high reset.
- in_valid  input  1  ID-stage instruction valid.
- stall  input  1  hold stage contents (hazard unit).
- flush  input  1  kill stage contents (branch/jump).
- rs_addr  input  REG_AW  rs register number.
- rt_addr  input  REG_AW  rt register number.
- rs_data  input  DATA_W  register-file rs value.
- rt_data  input  DATA_W  register-file rt value.
- ext_imm  input  DATA_W  extended immediate.
- shamt  input  REG_AW  shift amount field.
- alu_src_a  input  2  A select: 00 rs, 01 rt, 10 ext_imm, 11 illegal.
- alu_src_b  input  3  B select: 000 rt, 001 rs, 010 ext_imm, 011 zero-extended shamt, 100 CONST_B, 101–111 illegal.
- exmem_wr  input  1  EX/MEM instruction writes a register.
- exmem_dst  input  REG_AW  EX/MEM destination register.
- exmem_data  input  DATA_W  EX/MEM result.
- memwb_wr  input  1  MEM/WB instruction writes a register.
- memwb_dst  input  REG_AW  MEM/WB destination register.
- memwb_data  input  DATA_W  MEM/WB writeback value.
- in1  output  DATA_W  registered ALU operand A.
- in2  output  DATA_W  registered ALU operand B.
- out_valid  output  1  registered operands valid.
- sel_err  output  1  registered: the captured instruction used an illegal select.
- fwd_a  output  2  registered forward source for rs (00 none, 01 MEM/WB, 10 EX/MEM); debug use.
- fwd_b  output  2  registered forward source for rt; same encoding as fwd_a.

Behaviour:
- Reset: clk rising edge with reset=1 clears in1, in2, out_valid, sel_err, fwd_a and fwd_b to 0. Reset overrides stall and flush.
- Forwarding (combinational, applied before the select mux):
  - rs_fwd = exmem_data if exmem_wr and exmem_dst==rs_addr and rs_addr!=0.
  - Otherwise memwb_data if memwb_wr and memwb_dst==rs_addr and rs_addr!=0.
  - Otherwise rs_data.
  - EX/MEM has priority over MEM/WB. Register 0 is never forwarded.
  - rt_fwd is identical with rt_addr.
- Selection:
  - A chooses from rs_fwd, rt_fwd or ext_imm. Code 11 yields 0 and asserts the error.
  - B chooses from rt_fwd, rs_fwd, ext_imm, {zeros, shamt}, or CONST_B zero-extended to DATA_W. Codes 101–111 yield 0 and assert the error.
  - Fully combinational with a default for every code; no latches.
- Register update, priority order on each clk edge:
  1. reset.
  2. flush: out_valid←0, sel_err←0, in1/in2 cleared to 0.
  3. stall: all outputs hold.
  4. Otherwise: capture in1, in2 and the forward codes; out_valid←in_valid; sel_err←in_valid & illegal.
- Simultaneous stall and flush: flush wins.
- Latency: exactly 1 cycle from input to output. One instruction per cycle when not stalled.
- in_valid=0 with no stall: operands are still captured (don't-care) and out_valid=0. sel_err is only raised for valid instructions.
- Reset asserted mid-stall: outputs clear. Stall does not hold across reset.

Decomposition:
- Shared package alu_pkg holds:
  - select encodings: SRC_A_RS/RT/IMM, SRC_B_RT/RS/IMM/SHAMT/CONST.
  - forward codes: FWD_NONE/MEMWB/EXMEM.
  - DATA_W default.
- One sub-module, fwd_select: pure combinational forwarding for a single operand (addr, rf data, two bypass ports → data, code). Instantiated twice, for rs and rt.
- The mux and pipeline register live in the top level.

Test Plan:
- Reset and basic select: reset 2 cycles, then rs_data=0x11, ext_imm=0x22, src_a=00, src_b=010, in_valid=1 → next cycle in1=0x11, in2=0x22, out_valid=1, fwd_a=fwd_b=00.
- Forward priority: rs_addr=5, exmem (wr=1, dst=5, data=0xAAAA), memwb (wr=1, dst=5, data=0xBBBB), src_a=00 → in1=0xAAAA, fwd_a=10. Drop exmem_wr → in1=0xBBBB, fwd_a=01.
- Register zero: rt_addr=0, exmem_dst=0, exmem_wr=1, rt_data=0, src_b=000 → in2=0, fwd_b=00.
- Shamt and constant: shamt=5'h1F, src_b=011 → in2=0x0000001F. src_b=100 → in2=16.
- Illegal select: src_a=11, src_b=110, in_valid=1 → in1=0, in2=0, sel_err=1. Same with in_valid=0 → sel_err=0.
- Stall/flush: capture in1=0x11; stall=1 for 3 cycles with changing inputs → in1 stays 0x11, out_valid stays 1. Stall=1 with flush=1 → out_valid=0, in1=0. Reset during stall → all outputs 0.
